// File: rtl/typedef_pkg.sv
// Shared types for the ROB completion arbiter: source encoding, branch payload
// and the modulo-3 round-robin step.
package typedef_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned ROB_ID_WIDTH = 4;

    // Generic completion sources; the encoding doubles as the round-robin pointer value.
    typedef enum logic [1:0] {
        SRC_ALU   = 2'd0,
        SRC_LOAD  = 2'd1,
        SRC_STORE = 2'd2
    } CMPL_SRC_t;

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0] rob_id;
        logic                    mispredict;
        logic                    actual_taken;
        logic [ADDR_WIDTH-1:0]   actual_target;
        logic [ADDR_WIDTH-1:0]   update_pc;
    } BR_CMPL_t;

    // Next source in round-robin order; never yields 3.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/cmpl_hold_reg.sv
// One-entry valid/ready holding register. A grant frees the slot in the same
// cycle so a new payload can be loaded at the edge that retires the old one.
module cmpl_hold_reg #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic in_valid_i,
    input  T     in_data_i,
    output logic in_ready_o,
    input  logic grant_i,
    output logic held_valid_o,
    output T     held_data_o
);

    logic valid_q, valid_d;
    T     data_q, data_d;
    logic accept;

    // Ready when empty or draining this cycle; suppressed in reset and flush.
    always_comb begin
        in_ready_o = rst_ni && !flush_i && (!valid_q || grant_i);
        accept     = in_valid_i && in_ready_o;
        valid_d    = valid_q;
        data_d     = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (grant_i) begin
            valid_d = 1'b0;
        end
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign held_valid_o = valid_q;
    assign held_data_o  = data_q;

endmodule

// File: rtl/rob_completion_arbiter.sv
// Completion-side scheduler: four holding registers feeding two ROB completion
// ports. Branches own port 0; ALU/LOAD/STORE share the ports round-robin.
module rob_completion_arbiter #(
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH = typedef_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  alu_cmpl_valid,
    input  logic [ROB_WIDTH-1:0]  alu_cmpl_rob_id,
    output logic                  alu_cmpl_ready,
    input  logic                  load_cmpl_valid,
    input  logic [ROB_WIDTH-1:0]  load_cmpl_rob_id,
    output logic                  load_cmpl_ready,
    input  logic                  store_cmpl_valid,
    input  logic [ROB_WIDTH-1:0]  store_cmpl_rob_id,
    output logic                  store_cmpl_ready,
    input  logic                  br_cmpl_valid,
    input  logic [ROB_WIDTH-1:0]  br_cmpl_rob_id,
    input  logic                  br_mispredict,
    input  logic                  br_actual_taken,
    input  logic [ADDR_WIDTH-1:0] br_actual_target,
    input  logic [ADDR_WIDTH-1:0] br_update_pc,
    output logic                  br_cmpl_ready,
    output logic                  rob_cmpl0_valid,
    output logic                  rob_cmpl0_is_branch,
    output logic [ROB_WIDTH-1:0]  rob_cmpl0_rob_id,
    output logic                  rob_br_mispredict,
    output logic                  rob_br_actual_taken,
    output logic [ADDR_WIDTH-1:0] rob_br_actual_target,
    output logic [ADDR_WIDTH-1:0] rob_br_update_pc,
    output logic                  rob_cmpl1_valid,
    output logic [ROB_WIDTH-1:0]  rob_cmpl1_rob_id
);

    import typedef_pkg::*;

    logic [1:0]           rr_q, rr_d;
    logic [2:0]           gen_v;
    logic [2:0]           gen_grant;
    logic [ROB_WIDTH-1:0] gen_id [3];
    logic                 br_v;
    logic                 br_grant;
    BR_CMPL_t             br_in, br_q;

    logic                 active;
    logic                 found0, found1;
    CMPL_SRC_t            first_src, second_src;
    logic                 p0_gen, p1_gen;
    CMPL_SRC_t            p0_src, p1_src;

    assign active = rst_n && !flush;

    assign br_in = '{rob_id:        br_cmpl_rob_id,
                     mispredict:    br_mispredict,
                     actual_taken:  br_actual_taken,
                     actual_target: br_actual_target,
                     update_pc:     br_update_pc};

    cmpl_hold_reg #(.T(logic [ROB_WIDTH-1:0])) u_hold_alu (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .in_valid_i   (alu_cmpl_valid),
        .in_data_i    (alu_cmpl_rob_id),
        .in_ready_o   (alu_cmpl_ready),
        .grant_i      (gen_grant[0]),
        .held_valid_o (gen_v[0]),
        .held_data_o  (gen_id[0])
    );

    cmpl_hold_reg #(.T(logic [ROB_WIDTH-1:0])) u_hold_load (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .in_valid_i   (load_cmpl_valid),
        .in_data_i    (load_cmpl_rob_id),
        .in_ready_o   (load_cmpl_ready),
        .grant_i      (gen_grant[1]),
        .held_valid_o (gen_v[1]),
        .held_data_o  (gen_id[1])
    );

    cmpl_hold_reg #(.T(logic [ROB_WIDTH-1:0])) u_hold_store (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .in_valid_i   (store_cmpl_valid),
        .in_data_i    (store_cmpl_rob_id),
        .in_ready_o   (store_cmpl_ready),
        .grant_i      (gen_grant[2]),
        .held_valid_o (gen_v[2]),
        .held_data_o  (gen_id[2])
    );

    cmpl_hold_reg #(.T(BR_CMPL_t)) u_hold_br (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .in_valid_i   (br_cmpl_valid),
        .in_data_i    (br_in),
        .in_ready_o   (br_cmpl_ready),
        .grant_i      (br_grant),
        .held_valid_o (br_v),
        .held_data_o  (br_q)
    );

    // Scan generic sources from rr_q and keep the first two that are valid.
    always_comb begin
        logic [1:0] idx;
        found0     = 1'b0;
        found1     = 1'b0;
        first_src  = SRC_ALU;
        second_src = SRC_ALU;
        idx        = rr_q;
        for (int k = 0; k < 3; k++) begin
            if (gen_v[idx]) begin
                if (!found0) begin
                    found0    = 1'b1;
                    first_src = CMPL_SRC_t'(idx);
                end else if (!found1) begin
                    found1     = 1'b1;
                    second_src = CMPL_SRC_t'(idx);
                end
            end
            idx = rr_next(idx);
        end
    end

    // Port assignment, grants and round-robin advance. A held branch pushes the
    // first generic pick onto port 1, so only one generic goes out that cycle.
    always_comb begin
        br_grant  = 1'b0;
        gen_grant = 3'b000;
        p0_gen    = 1'b0;
        p1_gen    = 1'b0;
        p0_src    = SRC_ALU;
        p1_src    = SRC_ALU;
        rr_d      = rr_q;
        if (flush) begin
            rr_d = 2'd0;
        end else if (active) begin
            if (br_v) begin
                br_grant = 1'b1;
                if (found0) begin
                    p1_gen = 1'b1;
                    p1_src = first_src;
                end
            end else if (found0) begin
                p0_gen = 1'b1;
                p0_src = first_src;
                if (found1) begin
                    p1_gen = 1'b1;
                    p1_src = second_src;
                end
            end
            if (p0_gen) gen_grant[p0_src] = 1'b1;
            if (p1_gen) gen_grant[p1_src] = 1'b1;
            // The last generic in search order decides where the next scan starts.
            if (p1_gen)      rr_d = rr_next(p1_src);
            else if (p0_gen) rr_d = rr_next(p0_src);
        end
    end

    // ROB-facing outputs, all zero unless something is granted.
    always_comb begin
        rob_cmpl0_valid      = br_grant || p0_gen;
        rob_cmpl0_is_branch  = br_grant;
        rob_cmpl0_rob_id     = '0;
        rob_br_mispredict    = 1'b0;
        rob_br_actual_taken  = 1'b0;
        rob_br_actual_target = '0;
        rob_br_update_pc     = '0;
        rob_cmpl1_valid      = p1_gen;
        rob_cmpl1_rob_id     = '0;
        if (br_grant) begin
            rob_cmpl0_rob_id     = br_q.rob_id;
            rob_br_mispredict    = br_q.mispredict;
            rob_br_actual_taken  = br_q.actual_taken;
            rob_br_actual_target = br_q.actual_target;
            rob_br_update_pc     = br_q.update_pc;
        end else if (p0_gen) begin
            rob_cmpl0_rob_id = gen_id[p0_src];
        end
        if (p1_gen) rob_cmpl1_rob_id = gen_id[p1_src];
    end

    // Round-robin pointer with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) rr_q <= 2'd0;
        else        rr_q <= rr_d;
    end

endmodule
